mfhwt_upsample2x: RTL
=====================

Name: mfhwt_upsample2x

Overview:
- Inverse-direction counterpart of the MFHWT averaging path: expands a low-resolution 8-bit pixel stream by 2x horizontally and 2x vertically.
- Input is 16-bit words carrying two pixels each, the same format the MFHWT pipeline emits.
- Output is 32-bit words carrying four pixels each, the same format the MFHWT front end accepts.
- Used to rebuild a displayable frame from a decimated level, e.g. for overlay or debug video.
- Internal ping-pong line buffer: the next low-res row is written while the current row is emitted twice.

Parameters:
- LINE_WORDS, 160, 16-bit input words per low-res row (320 low-res pixels → 640 output pixels).
- ADDR_W, 8, line-buffer address width; must satisfy 2^ADDR_W >= LINE_WORDS.

Ports:
- iClk, in, 1, clock; all logic is rising-edge.
- iReset_n, in, 1, asynchronous active-low reset.
- iInput_ready, in, 1, input word valid.
- iData_in, in, 16, [7:0]=pixel p0 (left), [15:8]=pixel p1.
- oInput_accept, out, 1, block can take a word this cycle; a transfer happens when iInput_ready && oInput_accept.
- iOutput_accept, in, 1, downstream takes the output word this cycle.
- oOutput_ready, out, 1, oData_out is valid.
- oData_out, out, 32, four output pixels; [7:0] is leftmost.
- oLine_last, out, 1, high with the final output word of each output row.

Behaviour:
- Reset (async, iReset_n=0):
  - oInput_accept=0, oOutput_ready=0, oData_out=0, oLine_last=0.
  - Both banks marked empty; write bank=0, write address=0.
  - Reader state=IDLE.
  - oInput_accept rises on the first clock after reset is released.
- Reset asserted mid-row or mid-emission discards all buffered data. No partial row is ever emitted afterwards.
- Line buffer:
  - Two banks of LINE_WORDS x 16, with synchronous read (1-cycle latency).
  - Each bank has a full flag.
- Write side:
  - oInput_accept = ~full[wr_bank].
  - Each transfer writes iData_in at wr_addr, then wr_addr increments.
  - On the transfer at wr_addr=LINE_WORDS-1: set full[wr_bank], reset wr_addr to 0, toggle wr_bank.
- Reader FSM:
  - IDLE → PASS0 when full[rd_bank]=1. Start at address 0.
  - PASS0 → PASS1 after the word at address LINE_WORDS-1 is accepted.
  - PASS1 → IDLE after its last word is accepted. On that same edge: clear full[rd_bank] and toggle rd_bank.
  - If the other bank is already full, go from PASS1 directly to PASS0. No bubble is allowed in this case.
- Output register:
  - oData_out, oOutput_ready and oLine_last are registered.
  - While oOutput_ready=1 and iOutput_accept=0, all three hold stable.
  - Use a one-entry skid register or a prefetch-on-accept scheme so that a continuous accept gives 1 word/cycle.
- Output word format (default): {p1,p1,p0,p0}, i.e. [7:0]=p0, [15:8]=p0, [23:16]=p1, [31:24]=p1.
- Output row count: each low-res row produces 2 output rows of LINE_WORDS words. oLine_last is high on the words at address LINE_WORDS-1 in both PASS0 and PASS1.
- Latency: if the last word of a row is accepted at edge T with the reader in IDLE, oOutput_ready=1 after edge T+2.
- Throughput: with iOutput_accept held high, 2*LINE_WORDS consecutive valid cycles per row.
- Bank freeing and full flags:
  - A bank freed at edge T gives oInput_accept=1 after edge T.
  - If set-full and clear-full target different banks on the same edge, both take effect.
  - Input is stalled (oInput_accept=0) only while both banks are full.

Optional Feature:
- Macro: MFHWT_UPS_HINTERP_EN.
- Defined: horizontal linear interpolation within each word. Output is {p1, p1, avg, p0}, where avg=(p0+p1+1)>>1 is computed with a 9-bit sum. Added to the output path with no extra latency.
- Not defined: pure pixel replication, {p1,p1,p0,p0}, and no adder is synthesised.

Test Plan:
- LINE_WORDS=4; feed words 0x2010,0x4030,0x6050,0x8070 with iOutput_accept=1 → 8 outputs: 0x20201010,0x40403030,0x60605050,0x80807070, then the same 4 again. oLine_last is high on the 4th and 8th words. First valid 2 cycles after the 4th accept.
- Stream 3 rows back to back with iInput_ready=1 and iOutput_accept=1 → 24 contiguous output cycles with no bubble between rows. oInput_accept drops only while both banks are full.
- Hold iOutput_accept=0 for 5 cycles mid-row → oData_out and oLine_last stay stable; no word is lost or duplicated after accept resumes.
- Pulse iReset_n low during PASS0 of row 1 → all outputs 0 immediately. After release, the next complete row is emitted correctly; no stale words appear.
- Fill both banks while output is stalled → oInput_accept=0. One cycle after the first bank's final PASS1 word is accepted, oInput_accept=1.
- With MFHWT_UPS_HINTERP_EN defined, input 0x0301 → output 0x03030201. Input 0xFF00 → 0xFFFF8000, with rounding and no overflow.

Source files
------------

// File: rtl/mfhwt_upsample2x.sv
// ============================================================================
// Module   : mfhwt_upsample2x
// Brief    : 2x horizontal / 2x vertical pixel upsampler with ping-pong line
//            buffer. Optional macro MFHWT_UPS_HINTERP_EN enables in-word
//            horizontal interpolation.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mfhwt_upsample2x #(
  parameter int LINE_WORDS = 160,
  parameter int ADDR_W     = 8
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iInput_ready,
  input  logic [15:0] iData_in,
  output logic        oInput_accept,
  input  logic        iOutput_accept,
  output logic        oOutput_ready,
  output logic [31:0] oData_out,
  output logic        oLine_last
);

  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS0 = 2'd1,
    S_PASS1 = 2'd2
  } state_t;

  logic [15:0]       r_bank0 [LINE_WORDS];
  logic [15:0]       r_bank1 [LINE_WORDS];

  logic [1:0]        r_full;
  logic [1:0]        w_fullNext;
  logic              r_wrBank;
  logic              w_wrBankNext;
  logic [ADDR_W-1:0] r_wrAddr;
  logic              r_inAccept;
  logic              r_clrBank;
  logic              w_xfer;
  logic              w_wrLast;
  logic              w_clr;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [ADDR_W-1:0] w_rdAddrNext;
  logic              r_rdBank;
  logic              w_rdBankNext;
  logic              w_canRead;
  logic              w_issue;
  logic              w_issueLast;
  logic              w_issueEnd;

  logic [15:0]       r_rdData;
  logic              r_rdValid;
  logic              r_rdLast;
  logic              r_rdEnd;
  logic              w_stageFree;

  logic              r_outValid;
  logic [31:0]       r_outData;
  logic              r_outLast;
  logic              r_outEnd;
  logic              w_outFree;
  logic [31:0]       w_pix;

  // ---------------------------------------------------------------- write side
  assign w_xfer   = iInput_ready & r_inAccept;
  assign w_wrLast = w_xfer & (r_wrAddr == C_LAST_ADDR);
  assign w_clr    = r_outValid & iOutput_accept & r_outEnd;

  always_comb begin
    w_fullNext = r_full;
    if (w_clr)
      w_fullNext[r_clrBank] = 1'b0;
    if (w_wrLast)
      w_fullNext[r_wrBank] = 1'b1;
    w_wrBankNext = r_wrBank ^ w_wrLast;
  end

  // Accept is registered from next-state so it is low during reset and
  // rises on the first clock after release.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_full     <= 2'b00;
      r_wrBank   <= 1'b0;
      r_wrAddr   <= '0;
      r_inAccept <= 1'b0;
      r_clrBank  <= 1'b0;
    end else begin
      r_full     <= w_fullNext;
      r_wrBank   <= w_wrBankNext;
      r_inAccept <= ~w_fullNext[w_wrBankNext];
      r_clrBank  <= r_clrBank ^ w_clr;
      if (w_wrLast)
        r_wrAddr <= '0;
      else if (w_xfer)
        r_wrAddr <= r_wrAddr + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (w_xfer) begin
      if (r_wrBank)
        r_bank1[r_wrAddr] <= iData_in;
      else
        r_bank0[r_wrAddr] <= iData_in;
    end
    if (w_issue)
      r_rdData <= r_rdBank ? r_bank1[r_rdAddr] : r_bank0[r_rdAddr];
  end

  // --------------------------------------------------------------- reader FSM
  // The FSM tracks read issue, running up to two words ahead of the output.
  // Bank release happens only when the row's final word leaves the output.
  assign w_outFree   = ~r_outValid | iOutput_accept;
  assign w_stageFree = ~r_rdValid | w_outFree;
  assign w_canRead   = (r_state != S_IDLE) | r_full[r_rdBank];
  assign w_issue     = w_canRead & w_stageFree;

  always_comb begin
    w_stateNext  = r_state;
    w_rdAddrNext = r_rdAddr;
    w_rdBankNext = r_rdBank;
    w_issueLast  = (r_rdAddr == C_LAST_ADDR);
    w_issueEnd   = (r_rdAddr == C_LAST_ADDR) & (r_state == S_PASS1);
    if (w_issue) begin
      if (r_rdAddr == C_LAST_ADDR) begin
        w_rdAddrNext = '0;
        if (r_state != S_PASS1) begin
          w_stateNext = S_PASS1;
        end else begin
          w_rdBankNext = ~r_rdBank;
          w_stateNext  = r_full[~r_rdBank] ? S_PASS0 : S_IDLE;
        end
      end else begin
        w_rdAddrNext = r_rdAddr + 1'b1;
        w_stateNext  = (r_state == S_PASS1) ? S_PASS1 : S_PASS0;
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state  <= S_IDLE;
      r_rdAddr <= '0;
      r_rdBank <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_rdAddr <= w_rdAddrNext;
      r_rdBank <= w_rdBankNext;
    end
  end

  // ------------------------------------------------------------ output path
  `ifdef MFHWT_UPS_HINTERP_EN
  logic [8:0] w_sum;
  logic [7:0] w_avg;
  assign w_sum = {1'b0, r_rdData[7:0]} + {1'b0, r_rdData[15:8]} + 9'd1;
  assign w_avg = 8'(w_sum >> 1);
  assign w_pix = {r_rdData[15:8], r_rdData[15:8], w_avg, r_rdData[7:0]};
  `else
  assign w_pix = {r_rdData[15:8], r_rdData[15:8], r_rdData[7:0], r_rdData[7:0]};
  `endif

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_rdValid  <= 1'b0;
      r_rdLast   <= 1'b0;
      r_rdEnd    <= 1'b0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outLast  <= 1'b0;
      r_outEnd   <= 1'b0;
    end else begin
      if (w_issue) begin
        r_rdValid <= 1'b1;
        r_rdLast  <= w_issueLast;
        r_rdEnd   <= w_issueEnd;
      end else if (w_outFree) begin
        r_rdValid <= 1'b0;
      end
      if (w_outFree) begin
        r_outValid <= r_rdValid;
        r_outLast  <= r_rdValid & r_rdLast;
        r_outEnd   <= r_rdValid & r_rdEnd;
        if (r_rdValid)
          r_outData <= w_pix;
      end
    end
  end

  assign oInput_accept = r_inAccept;
  assign oOutput_ready = r_outValid;
  assign oData_out     = r_outData;
  assign oLine_last    = r_outLast;

endmodule

`default_nettype wire
